// File: rtl/lsu_controller.sv
// Load/store unit controller: one memory access at a time over a req/gnt/rvalid
// bus, with byte-lane steering, load extension and misalignment detection.
module lsu_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        acc_err;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [31:0] lane_word;
    logic [31:0] load_ext;

    // Decode of the incoming request: legality, lane enables and replicated data.
    always_comb begin
        acc_err   = 1'b0;
        acc_be    = 4'b0000;
        acc_wdata = req_wdata;
        case (req_funct3)
            3'b000, 3'b100: begin
                acc_be    = 4'b0001 << req_addr[1:0];
                acc_wdata = {4{req_wdata[7:0]}};
                acc_err   = req_we & req_funct3[2];
            end
            3'b001, 3'b101: begin
                acc_be    = 4'b0011 << {req_addr[1], 1'b0};
                acc_wdata = {2{req_wdata[15:0]}};
                acc_err   = req_addr[0] | (req_we & req_funct3[2]);
            end
            3'b010: begin
                acc_be  = 4'b1111;
                acc_err = (req_addr[1:0] != 2'b00);
            end
            default: acc_err = 1'b1;
        endcase
    end

    // Halfword accesses are known aligned here, so a byte-offset shift also
    // brings the addressed half down to bit 0.
    always_comb begin
        lane_word = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_ext = {24'h0, lane_word[7:0]};
            3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_ext = {16'h0, lane_word[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    if (acc_err) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                        state_d     = S_RESP;
                    end else begin
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = acc_be;
                        mem_wdata_d = acc_wdata;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    if (mem_we_q) begin
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = 32'h0;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_ext;
                    state_d     = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign rsp_valid = (state_q == S_RESP);
    // Released in RESP so the instruction advances together with its response.
    assign stall     = ((state_q == S_IDLE) & req_valid) | (state_q == S_REQ) | (state_q == S_WAIT);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Bench for lsu_controller: directed and randomized accesses checked against a
// size/offset arithmetic model of the load/store rules.
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready, stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int vecs = 0;
    int errs = 0;

    lsu_controller dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .req_ready(req_ready),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes; 0 marks an illegal width code.
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic m_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        int sz = m_size(f3);
        if (sz == 0) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (int'(addr[1:0]) % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [2:0] f3);
        int sz = m_size(f3);
        int mask = ((1 << sz) - 1) << int'(addr[1:0]);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [2:0] f3);
        case (m_size(f3))
            1:       return {4{w[7:0]}};
            2:       return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [2:0] f3);
        int sz = m_size(f3);
        logic [31:0] v, mask;
        v    = word >> (8 * int'(addr[1:0]));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v    = v & mask;
        if (!f3[2] && sz < 4 && (((v >> (8 * sz - 1)) & 32'h1) == 32'h1)) v = v | ~mask;
        return v;
    endfunction

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input int gdly, input int rdly,
                           input logic [31:0] word, input string tag);
        logic        e;
        logic [3:0]  be;
        logic [31:0] wd, rd, aa;
        e  = m_err(we, addr, f3);
        be = m_be(addr, f3);
        wd = m_wdata(wdata, f3);
        rd = (e || we) ? 32'h0 : m_rdata(word, addr, f3);
        aa = {addr[31:2], 2'b00};

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        #1;
        vecs++;
        if ({req_ready, stall, rsp_valid} !== 3'b110) begin
            errs++;
            $display("FAIL %s accept ready/stall/rsp_valid got %b want 110", tag, {req_ready, stall, rsp_valid});
        end
        tick();
        req_valid = 1'b0;
        if (!e) begin
            for (int i = 0; i <= gdly; i++) begin
                mem_gnt    = (i == gdly);
                mem_rvalid = 1'($urandom_range(0, 1));
                #1;
                vecs++;
                if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, rsp_valid} !==
                    {1'b1, we, aa, be, wd, 1'b1, 1'b0}) begin
                    errs++;
                    $display("FAIL %s bus req=%b we=%b addr=%h be=%b wdata=%h stall=%b rv=%b want req=1 we=%b addr=%h be=%b wdata=%h stall=1 rv=0",
                             tag, mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, rsp_valid, we, aa, be, wd);
                end
                tick();
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (!we) begin
                for (int i = 0; i <= rdly; i++) begin
                    mem_rvalid = (i == rdly);
                    mem_rdata  = (i == rdly) ? word : $urandom;
                    mem_gnt    = 1'($urandom_range(0, 1));
                    #1;
                    vecs++;
                    if ({mem_req, stall, rsp_valid, req_ready} !== 4'b0100) begin
                        errs++;
                        $display("FAIL %s wait req/stall/rv/ready got %b want 0100", tag,
                                 {mem_req, stall, rsp_valid, req_ready});
                    end
                    tick();
                end
                mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = $urandom;
            end
        end
        vecs++;
        if ({rsp_valid, rsp_err, rsp_rdata, stall, req_ready, mem_req} !== {1'b1, e, rd, 3'b000}) begin
            errs++;
            $display("FAIL %s resp valid=%b err=%b rdata=%h stall=%b ready=%b req=%b want 1 %b %h 0 0 0",
                     tag, rsp_valid, rsp_err, rsp_rdata, stall, req_ready, mem_req, e, rd);
        end
        tick();
        vecs++;
        if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b0, 1'b1, e, rd}) begin
            errs++;
            $display("FAIL %s after-resp valid=%b ready=%b err=%b rdata=%h want 0 1 %b %h",
                     tag, rsp_valid, req_ready, rsp_err, rsp_rdata, e, rd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        vecs++;
        if ({req_ready, stall, rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
            errs++;
            $display("FAIL reset_state ready=%b stall=%b rv=%b err=%b rdata=%h req=%b we=%b addr=%h be=%b wdata=%h want all 0 except ready=1",
                     req_ready, stall, rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        rst_n = 1'b1;
        tick();
        vecs++;
        if ({req_ready, rsp_valid, mem_req} !== 3'b100) begin
            errs++;
            $display("FAIL reset_release ready/rv/req got %b want 100", {req_ready, rsp_valid, mem_req});
        end
    endtask

    task automatic test_loads();
        run_txn(1'b0, 32'h103, 32'h0, 3'b000, 0, 0, 32'h80FF_1234, "lb");
        run_txn(1'b0, 32'h103, 32'h0, 3'b100, 0, 0, 32'h80FF_1234, "lbu");
        run_txn(1'b0, 32'h202, 32'h0, 3'b001, 0, 0, 32'h8001_7FFF, "lh");
        run_txn(1'b0, 32'h202, 32'h0, 3'b101, 0, 0, 32'h8001_7FFF, "lhu");
        run_txn(1'b0, 32'h200, 32'h0, 3'b001, 1, 2, 32'h8001_7FFF, "lh_lo");
        run_txn(1'b0, 32'h30C, 32'h0, 3'b010, 2, 1, 32'h89AB_CDEF, "lw");
    endtask

    task automatic test_stores();
        run_txn(1'b1, 32'h3, 32'hDEAD_BEEF, 3'b000, 3, 0, 32'h0, "sb_delay");
        run_txn(1'b1, 32'h42, 32'hDEAD_BEEF, 3'b001, 0, 0, 32'h0, "sh");
        run_txn(1'b1, 32'h44, 32'hDEAD_BEEF, 3'b010, 1, 0, 32'h0, "sw");
    endtask

    task automatic test_errors();
        run_txn(1'b0, 32'h6, 32'h0, 3'b010, 0, 0, 32'h0, "err_lw_mis");
        run_txn(1'b1, 32'h8, 32'h1234_5678, 3'b101, 0, 0, 32'h0, "err_shu");
        run_txn(1'b0, 32'h11, 32'h0, 3'b001, 0, 0, 32'h0, "err_lh_odd");
        run_txn(1'b0, 32'h10, 32'h0, 3'b011, 0, 0, 32'h0, "err_f3_011");
        run_txn(1'b1, 32'h10, 32'h0, 3'b111, 0, 0, 32'h0, "err_f3_111");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_funct3 = 3'b010;
            tick();
            req_valid = 1'b0;
            vecs++;
            if (mem_req !== 1'b1) begin
                errs++;
                $display("FAIL rst_mid%0d pre mem_req got %b want 1", k, mem_req);
            end
            if (k == 1) begin
                mem_gnt = 1'b1;
                tick();
                mem_gnt = 1'b0;
            end
            rst_n = 1'b0;
            #1;
            vecs++;
            if ({mem_req, req_ready, rsp_valid} !== 3'b010) begin
                errs++;
                $display("FAIL rst_mid%0d in_reset req/ready/rv got %b want 010", k, {mem_req, req_ready, rsp_valid});
            end
            tick(); tick();
            rst_n = 1'b1;
            tick();
            mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
            tick();
            mem_rvalid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                vecs++;
                if ({rsp_valid, req_ready, mem_req} !== 3'b010) begin
                    errs++;
                    $display("FAIL rst_mid%0d late_rvalid rv/ready/req got %b want 010", k, {rsp_valid, req_ready, mem_req});
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1122_3344; req_funct3 = 3'b010;
        tick();
        req_we = 1'b0; req_addr = 32'h20;
        mem_gnt = 1'b1;
        #1;
        vecs++;
        if ({mem_req, mem_we, mem_addr, req_ready} !== {1'b1, 1'b1, 32'h10, 1'b0}) begin
            errs++;
            $display("FAIL b2b_sw_req req=%b we=%b addr=%h ready=%b want 1 1 00000010 0", mem_req, mem_we, mem_addr, req_ready);
        end
        tick();
        mem_gnt = 1'b0;
        vecs++;
        if ({rsp_valid, req_ready, stall, mem_req} !== 4'b1000) begin
            errs++;
            $display("FAIL b2b_sw_resp rv/ready/stall/req got %b want 1000", {rsp_valid, req_ready, stall, mem_req});
        end
        tick();
        vecs++;
        if ({rsp_valid, req_ready, stall, mem_req} !== 4'b0110) begin
            errs++;
            $display("FAIL b2b_idle rv/ready/stall/req got %b want 0110", {rsp_valid, req_ready, stall, mem_req});
        end
        tick();
        req_valid = 1'b0;
        vecs++;
        if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h20, 4'hF}) begin
            errs++;
            $display("FAIL b2b_lw_req req=%b we=%b addr=%h be=%b want 1 0 00000020 1111", mem_req, mem_we, mem_addr, mem_be);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        vecs++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            errs++;
            $display("FAIL b2b_lw_resp rv=%b err=%b rdata=%h want 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
